// File: rtl/knn_pkg.sv
// Shared types and defaults for the kNN training loader.
// Point format, FSM states and parameter defaults.
package knn_pkg;

  localparam int CoordW     = 16;
  localparam int NPointsDef = 17;
  localparam int ClassesDef = 2;
  localparam int LatencyDef = 2;

  typedef struct packed {
    logic [CoordW-1:0] x;
    logic [CoordW-1:0] y;
  } point_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY,
    ERROR
  } state_t;

endpackage

// File: rtl/knn_valid_pipe.sv
// Single-bit delay line for result strobes.
// Async clear on reset, sync flush when the table changes.
module knn_valid_pipe #(
  parameter int Depth = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  logic in_i,
  output logic out_o
);

  logic [Depth-1:0] sr;

  // shift the accept strobe toward the output
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr <= '0;
    end else if (flush_i) begin
      sr <= '0;
    end else begin
      sr <= (sr << 1) | Depth'(in_i);
    end
  end

  assign out_o = sr[Depth-1];

endmodule

// File: rtl/knn_train_loader.sv
// Serial loader for the kNN training table.
// Fills a flop bank, then forwards queries with a matched strobe.
module knn_train_loader
  import knn_pkg::*;
#(
  parameter int NPoints = NPointsDef,
  parameter int Classes = ClassesDef,
  parameter int Latency = LatencyDef,
  localparam int IW = $clog2(NPoints),
  localparam int CW = $clog2(Classes)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           load_start_i,
  input  logic                           wr_valid_i,
  output logic                           wr_ready_o,
  input  logic [31:0]                    wr_point_i,
  input  logic [CW-1:0]                  wr_class_i,
  input  logic                           wr_last_i,
  input  logic                           q_valid_i,
  output logic                           q_ready_o,
  input  logic [31:0]                    q_point_i,
  output logic [NPoints-1:0][31:0]       points_o,
  output logic [NPoints-1:0][CW-1:0]     classes_o,
  output logic [31:0]                    din_o,
  output logic                           res_valid_o,
  output logic                           table_ready_o,
  output logic                           err_o
);

  state_t         state_q;
  state_t         state_d;
  logic [IW-1:0]  wr_cnt;
  logic           cnt_last;
  logic           wr_acc;
  logic           q_acc;
  point_t         wr_pt;
  point_t         q_pt;

  assign wr_pt    = point_t'(wr_point_i);
  assign q_pt     = point_t'(q_point_i);
  assign cnt_last = (wr_cnt == IW'(NPoints - 1));

  // a restart in the same cycle discards any handshake
  assign wr_acc = wr_valid_i & wr_ready_o & ~load_start_i;
  assign q_acc  = q_valid_i & q_ready_o & ~load_start_i;

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state: restart wins, last flag must match the final slot
  always_comb begin
    state_d = state_q;
    if (load_start_i) begin
      state_d = LOAD;
    end else if (state_q == LOAD && wr_acc) begin
      if (wr_last_i != cnt_last) begin
        state_d = ERROR;
      end else if (cnt_last) begin
        state_d = READY;
      end
    end
  end

  // state-decoded handshakes and flags
  always_comb begin
    wr_ready_o    = 1'b0;
    q_ready_o     = 1'b0;
    table_ready_o = 1'b0;
    err_o         = 1'b0;
    unique case (state_q)
      LOAD:    wr_ready_o = 1'b1;
      READY: begin
        q_ready_o     = 1'b1;
        table_ready_o = 1'b1;
      end
      ERROR:   err_o = 1'b1;
      default: ;
    endcase
  end

  // training table: cleared on restart, filled one slot per beat
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      points_o  <= '0;
      classes_o <= '0;
      wr_cnt    <= '0;
    end else if (load_start_i) begin
      points_o  <= '0;
      classes_o <= '0;
      wr_cnt    <= '0;
    end else if (wr_acc) begin
      points_o[wr_cnt]  <= wr_pt;
      classes_o[wr_cnt] <= wr_class_i;
      wr_cnt            <= wr_cnt + IW'(1);
    end
  end

  // query register held until the next accepted query
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      din_o <= '0;
    end else if (q_acc) begin
      din_o <= q_pt;
    end
  end

  knn_valid_pipe #(
    .Depth (Latency + 1)
  ) u_valid_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (load_start_i),
    .in_i    (q_acc),
    .out_o   (res_valid_o)
  );

endmodule
